// File: rtl/lector_teclado_fifo_pkg.sv
// Shared definitions for the PS/2 keyboard front end: prefix codes, frame and
// event widths, receiver/decoder state encodings and the key event payload.
package lector_teclado_fifo_pkg;

    localparam logic [7:0]  PS2_CODE_E0 = 8'hE0;
    localparam logic [7:0]  PS2_CODE_F0 = 8'hF0;
    localparam int unsigned FRAME_W     = 11;
    localparam int unsigned EVENT_W     = 10;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_DATA  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_WAIT     = 2'd0,
        DEC_PFX_E0   = 2'd1,
        DEC_PFX_F0   = 2'd2,
        DEC_PFX_E0F0 = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/lector_teclado_fifo_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports: i_clk, i_rst (sync, active high), i_push/i_wr_data write side,
//        i_pop read side (ignored when empty), o_rd_data_c head entry,
//        o_full_c / o_empty_c status. Push while full is accepted only
//        together with a pop in the same cycle.
module lector_teclado_fifo_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty_c   = (r_wr_ptr == r_rd_ptr);
    assign o_full_c    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop       = i_pop & ~o_empty_c;
    assign w_push      = i_push & (~o_full_c | w_pop);
    assign o_rd_data_c = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/lector_teclado_fifo.sv
// PS/2 keyboard front end: synchronises and filters PS2C, deserialises
// 11-bit frames, decodes E0/F0 prefixes and queues {ext,brk,code} events
// in a FWFT FIFO.
// Ports: CLK, RST (sync, active high), PS2D/PS2C async PS/2 lines,
//        RD_EN pops head event; KEY_CODE/KEY_EXT/KEY_BREAK show the head,
//        KEY_VALID = not empty, FIFO_FULL, OVERFLOW (sticky drop flag),
//        FRAME_ERR / PARITY_ERR one-cycle error pulses.
// Build option: define PS2_PARITY_CHECK_EN to verify odd parity; otherwise
// the parity bit is ignored and PARITY_ERR is tied low.
module lector_teclado_fifo
    import lector_teclado_fifo_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2D,
    input  logic       PS2C,
    input  logic       RD_EN,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       KEY_VALID,
    output logic       FIFO_FULL,
    output logic       OVERFLOW,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR
);

    localparam int unsigned    TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic                  r_ps2c_s1, r_ps2c_s2, r_ps2d_s1, r_ps2d_s2;
    logic [FILTER_LEN-1:0] r_filt_sh;
    logic                  r_filt_clk, r_filt_clk_q;
    logic                  w_fall;

    rx_state_t             r_rx_state, w_rx_next;
    logic [FRAME_W-1:0]    r_sh;
    logic [3:0]            r_bit_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  w_shift_en, w_check_c, w_abort_c;
    logic                  w_frame_ok, w_byte_done_c, w_frame_err_c;
    logic                  r_frame_err;

    dec_state_t            r_dec_state, w_dec_next;
    logic                  w_push_c;
    key_event_t            w_event_c;
    logic [7:0]            w_rx_byte;

    logic [EVENT_W-1:0]    w_fifo_rd_data;
    logic                  w_fifo_full, w_fifo_empty;
    key_event_t            w_head;
    logic                  r_overflow;

    // Synchronisers and PS2C glitch filter; bus idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ps2c_s1    <= 1'b1;
            r_ps2c_s2    <= 1'b1;
            r_ps2d_s1    <= 1'b1;
            r_ps2d_s2    <= 1'b1;
            r_filt_sh    <= '1;
            r_filt_clk   <= 1'b1;
            r_filt_clk_q <= 1'b1;
        end else begin
            r_ps2c_s1    <= PS2C;
            r_ps2c_s2    <= r_ps2c_s1;
            r_ps2d_s1    <= PS2D;
            r_ps2d_s2    <= r_ps2d_s1;
            r_filt_sh    <= {r_filt_sh[FILTER_LEN-2:0], r_ps2c_s2};
            if (&r_filt_sh) begin
                r_filt_clk <= 1'b1;
            end else if (~|r_filt_sh) begin
                r_filt_clk <= 1'b0;
            end
            r_filt_clk_q <= r_filt_clk;
        end
    end

    assign w_fall = r_filt_clk_q & ~r_filt_clk;

    // Receiver state register.
    always_ff @(posedge CLK) begin
        if (RST) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // Receiver next state: 11 falls per frame, then one CHECK cycle.
    always_comb begin
        w_rx_next  = r_rx_state;
        w_shift_en = 1'b0;
        w_check_c  = 1'b0;
        w_abort_c  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    w_rx_next  = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 4'd10) w_rx_next = RX_CHECK;
                end else if (r_to_cnt == TO_LAST) begin
                    w_abort_c = 1'b1;
                    w_rx_next = RX_IDLE;
                end
            end
            RX_CHECK: begin
                w_check_c = 1'b1;
                w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Frame shifter (LSB first, so start ends in bit 0), bit and timeout counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_shift_en) begin
                r_sh      <= {r_ps2d_s2, r_sh[FRAME_W-1:1]};
                r_bit_cnt <= (r_rx_state == RX_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
            end
            if (w_fall || (r_rx_state != RX_DATA)) r_to_cnt <= '0;
            else                                   r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_frame_ok    = ~r_sh[0] & r_sh[10];
    assign w_rx_byte     = r_sh[8:1];
    assign w_frame_err_c = (w_check_c & ~w_frame_ok) | w_abort_c;

`ifdef PS2_PARITY_CHECK_EN
    logic w_par_ok;
    logic w_par_err_c;
    logic r_parity_err;

    assign w_par_ok      = odd_parity_ok(r_sh[9:1]);
    assign w_byte_done_c = w_check_c & w_frame_ok & w_par_ok;
    assign w_par_err_c   = w_check_c & w_frame_ok & ~w_par_ok;

    always_ff @(posedge CLK) begin
        if (RST) r_parity_err <= 1'b0;
        else     r_parity_err <= w_par_err_c;
    end

    assign PARITY_ERR = r_parity_err;
`else
    logic w_unused_parity;

    assign w_unused_parity = r_sh[9];
    assign w_byte_done_c   = w_check_c & w_frame_ok;
    assign PARITY_ERR      = 1'b0;
`endif

    // Decoder state register.
    always_ff @(posedge CLK) begin
        if (RST) r_dec_state <= DEC_WAIT;
        else     r_dec_state <= w_dec_next;
    end

    // Prefix decoder: only a pushed event returns it to WAIT.
    always_comb begin
        w_dec_next = r_dec_state;
        w_push_c   = 1'b0;
        w_event_c  = '0;
        if (w_byte_done_c) begin
            if (w_rx_byte == PS2_CODE_E0) begin
                w_dec_next = DEC_PFX_E0;
            end else if (w_rx_byte == PS2_CODE_F0) begin
                w_dec_next = ((r_dec_state == DEC_PFX_E0) || (r_dec_state == DEC_PFX_E0F0))
                             ? DEC_PFX_E0F0 : DEC_PFX_F0;
            end else begin
                w_push_c       = 1'b1;
                w_event_c.ext  = (r_dec_state == DEC_PFX_E0) || (r_dec_state == DEC_PFX_E0F0);
                w_event_c.brk  = (r_dec_state == DEC_PFX_F0) || (r_dec_state == DEC_PFX_E0F0);
                w_event_c.code = w_rx_byte;
                w_dec_next     = DEC_WAIT;
            end
        end
    end

    // Error pulse and sticky overflow; a pop in the push cycle frees a slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_c;
            if (w_push_c && w_fifo_full && !RD_EN) r_overflow <= 1'b1;
        end
    end

    lector_teclado_fifo_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_push      (w_push_c),
        .i_wr_data   (w_event_c),
        .i_pop       (RD_EN),
        .o_rd_data_c (w_fifo_rd_data),
        .o_full_c    (w_fifo_full),
        .o_empty_c   (w_fifo_empty)
    );

    assign w_head    = key_event_t'(w_fifo_rd_data);
    assign KEY_CODE  = w_head.code;
    assign KEY_EXT   = w_head.ext;
    assign KEY_BREAK = w_head.brk;
    assign KEY_VALID = ~w_fifo_empty;
    assign FIFO_FULL = w_fifo_full;
    assign OVERFLOW  = r_overflow;
    assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_lector_teclado_fifo.sv
// Self-checking bench for lector_teclado_fifo: directed table, corner-case
// sequences and randomized frames against a queue-based reference model.
// Build option: PS2_PARITY_CHECK_EN changes the expected bad-parity outcome.
module tb_lector_teclado_fifo;

    localparam int unsigned HALF  = 80;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, fifo_full, overflow, frame_err, parity_err;

    int checks = 0;
    int failures = 0;
    int frame_err_cnt = 0;
    int par_err_cnt = 0;
    int exp_par_err = 0;

    always #5 clk = ~clk;

    lector_teclado_fifo #(
        .FILTER_LEN  (8),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (2000)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PS2D       (ps2d),
        .PS2C       (ps2c),
        .RD_EN      (rd_en),
        .KEY_CODE   (key_code),
        .KEY_EXT    (key_ext),
        .KEY_BREAK  (key_break),
        .KEY_VALID  (key_valid),
        .FIFO_FULL  (fifo_full),
        .OVERFLOW   (overflow),
        .FRAME_ERR  (frame_err),
        .PARITY_ERR (parity_err)
    );

    always @(negedge clk) begin
        if (frame_err)  frame_err_cnt++;
        if (parity_err) par_err_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame bit i is transmitted i-th: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
        logic p;
        p = (~^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2d = b;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] f;
        f = frame_bits(b, 1'b0);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        @(negedge clk) ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        send_partial(8'h00, 0);
        begin
            logic [10:0] f;
            f = frame_bits(b, bad);
            for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        end
        @(negedge clk) ps2d = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    // Reference model: event queue plus pending prefix flags.
    logic [9:0] mq[$];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_ovf = 1'b0;

    task automatic model_byte(input logic [7:0] b, input bit bad);
`ifdef PS2_PARITY_CHECK_EN
        if (bad) begin
            exp_par_err++;
            return;
        end
`endif
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else                    mq.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, int'(key_valid), int'(mq.size() > 0));
        chk({tag, ".full"}, int'(fifo_full), int'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
        if (mq.size() > 0) begin
            chk({tag, ".code"}, int'(key_code), int'(mq[0][7:0]));
            chk({tag, ".ext"}, int'(key_ext), int'(mq[0][9]));
            chk({tag, ".brk"}, int'(key_break), int'(mq[0][8]));
        end
    endtask

    typedef struct {
        logic [7:0] b;
        bit         do_pop;
        bit         exp_valid;
        bit         exp_ext;
        bit         exp_brk;
        logic [7:0] exp_code;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int fe0, pe0;

        tbl[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C};
        tbl[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
        tbl[3] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{8'h75, 1'b1, 1'b1, 1'b1, 1'b1, 8'h75};

        // Reset state.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.valid", int'(key_valid), 0);
        chk("rst.full", int'(fifo_full), 0);
        chk("rst.ovf", int'(overflow), 0);
        chk("rst.ferr", int'(frame_err), 0);
        chk("rst.perr", int'(parity_err), 0);
        chk("rst.code", int'(key_code), 0);
        chk("rst.ext", int'(key_ext), 0);
        chk("rst.brk", int'(key_break), 0);

        // Directed byte table: make, break and extended break.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b, 1'b0);
            chk($sformatf("tbl%0d.valid", i), int'(key_valid), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d.code", i), int'(key_code), int'(tbl[i].exp_code));
                chk($sformatf("tbl%0d.ext", i), int'(key_ext), int'(tbl[i].exp_ext));
                chk($sformatf("tbl%0d.brk", i), int'(key_break), int'(tbl[i].exp_brk));
            end
            if (tbl[i].do_pop) begin
                pop();
                chk($sformatf("tbl%0d.popped", i), int'(key_valid), 0);
            end
        end
        chk("tbl.no_ferr", frame_err_cnt, 0);

        // Inverted parity.
        pe0 = par_err_cnt;
        send_frame(8'h2A, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("par.pulse", par_err_cnt - pe0, 1);
        chk("par.valid", int'(key_valid), 0);
        exp_par_err = 1;
`else
        chk("par.pulse", par_err_cnt - pe0, 0);
        chk("par.valid", int'(key_valid), 1);
        chk("par.code", int'(key_code), 8'h2A);
        pop();
`endif

        // Timeout on a truncated frame, then a clean frame.
        fe0 = frame_err_cnt;
        send_partial(8'h55, 5);
        repeat (2500) @(negedge clk);
        chk("to.pulse", frame_err_cnt - fe0, 1);
        chk("to.valid", int'(key_valid), 0);
        send_frame(8'h33, 1'b0);
        chk("to.next_valid", int'(key_valid), 1);
        chk("to.next_code", int'(key_code), 8'h33);
        chk("to.next_ext", int'(key_ext), 0);
        chk("to.no_more_ferr", frame_err_cnt - fe0, 1);
        pop();

        // Fill past capacity.
        for (int k = 0; k < 5; k++) send_frame(8'(8'h15 + k), 1'b0);
        chk("ovf.full", int'(fifo_full), 1);
        chk("ovf.flag", int'(overflow), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf.pop%0d.valid", k), int'(key_valid), 1);
            chk($sformatf("ovf.pop%0d.code", k), int'(key_code), 8'h15 + k);
            pop();
        end
        chk("ovf.empty", int'(key_valid), 0);
        chk("ovf.not_full", int'(fifo_full), 0);
        chk("ovf.sticky", int'(overflow), 1);
        pop();
        chk("ovf.empty_pop", int'(key_valid), 0);

        // Randomized frames against the reference model.
        m_ovf = 1'b1;
        for (int r = 0; r < 12; r++) begin
            logic [7:0] b;
            bit         bad;
            int         sel, npop;
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else               b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, bad);
            model_byte(b, bad);
            check_model($sformatf("rnd%0d", r));
            npop = int'($urandom_range(0, 2));
            for (int j = 0; j < npop; j++) begin
                if (mq.size() > 0) void'(mq.pop_front());
                pop();
            end
            check_model($sformatf("rnd%0d.post", r));
        end
        chk("rnd.par_err_cnt", par_err_cnt, exp_par_err);

        // Reset in the middle of a frame with events queued.
        for (int k = 0; k < 3; k++) send_frame(8'(8'h1A + k), 1'b0);
        chk("rst6.queued", int'(key_valid), 1);
        send_partial(8'h1C, 6);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst6.valid", int'(key_valid), 0);
        chk("rst6.full", int'(fifo_full), 0);
        chk("rst6.ovf", int'(overflow), 0);
        send_frame(8'h29, 1'b0);
        chk("rst6.next_valid", int'(key_valid), 1);
        chk("rst6.next_code", int'(key_code), 8'h29);
        chk("rst6.next_ext", int'(key_ext), 0);
        chk("rst6.next_brk", int'(key_break), 0);
        pop();
        chk("rst6.drained", int'(key_valid), 0);
        chk("all.ferr_cnt", frame_err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
